// File: rtl/rs_encode_arbiter.sv
// rs_encode_arbiter
//   Shares one RS encode engine between NUM_REQ requesters. A round-robin
//   grant picks one request, the engine is cleared, started and waited on,
//   and the captured codeword (or a timeout error) is returned to the owner
//   over a valid/ready response channel.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/ready_o     per-requester request handshake
//   req_data_i              requester i message at [i*DATA_W +: DATA_W]
//   rsp_valid_o/ready_i     per-requester response handshake
//   rsp_data_o, rsp_err_o   shared codeword and timeout flag
//   grant_id_o, busy_o      current owner, controller not idle
//   enc_*                   engine clear/start/data and codeword return
module rs_encode_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 336,
  parameter int CODE_W      = 400,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [CODE_W-1:0]           rsp_data_o,
  output logic                        rsp_err_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
  output logic                        busy_o,
  output logic                        enc_clrn_o,
  output logic                        enc_en_o,
  output logic [DATA_W-1:0]           enc_data_o,
  input  logic [CODE_W-1:0]           enc_code_i,
  input  logic                        enc_valid_i,
  input  logic                        enc_ready_i
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic            any_req;
  logic            grant;
  logic [CNT_W-1:0] to_cnt;

  // First requesting index at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req_valid_i[idx]) begin
        any_req = 1'b1;
        win     = ID_W'(idx);
      end
    end
  end

  // Reset is folded in so the request side also reads as idle while held.
  assign grant       = !rst_i && (state == S_IDLE) && enc_ready_i && any_req;
  assign req_ready_o = grant ? (NUM_REQ'(1) << win) : '0;
  assign rsp_valid_o = (state == S_RESP) ? (NUM_REQ'(1) << grant_id_o) : '0;
  assign enc_clrn_o  = (state != S_CLEAR);
  assign enc_en_o    = (state == S_START);
  assign busy_o      = (state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id_o <= '0;
      enc_data_o <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
      to_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            enc_data_o <= req_data_i[int'(win)*DATA_W +: DATA_W];
            grant_id_o <= win;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: state <= S_START;
        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // Engine valid takes priority over a coincident timeout.
          if (enc_valid_i) begin
            rsp_data_o <= enc_code_i;
            rsp_err_o  <= 1'b0;
            state      <= S_RESP;
          end else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
            state      <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i[grant_id_o]) begin
            rr_ptr <= (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encode_arbiter.sv
// Scoreboard bench for rs_encode_arbiter. A reference model predicts each
// grant from the round-robin rule, and at grant time pushes the expected
// response (owner, codeword or error, response cycle) into a queue. A monitor
// compares DUT outputs against the queue head every cycle. The bench also
// plays the engine, answering d cycles after the start pulse.
module tb_rs_encode_arbiter;
  localparam int N     = 2;
  localparam int DW    = 336;
  localparam int CW    = 400;
  localparam int TO    = 1024;
  localparam int NEVER = 5000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [CW-1:0]   rsp_data;
  logic            rsp_err;
  logic [0:0]      grant_id;
  logic            busy;
  logic            enc_clrn;
  logic            enc_en;
  logic [DW-1:0]   enc_data;
  logic [CW-1:0]   enc_code = '0;
  logic            enc_valid = 1'b0;
  logic            enc_ready = 1'b1;

  rs_encode_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CODE_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .grant_id_o(grant_id), .busy_o(busy),
    .enc_clrn_o(enc_clrn), .enc_en_o(enc_en), .enc_data_o(enc_data),
    .enc_code_i(enc_code), .enc_valid_i(enc_valid), .enc_ready_i(enc_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    int            g;     // grant cycle
    int            t;     // first cycle rsp_valid is expected
    bit            err;
    logic [CW-1:0] code;
  } exp_t;

  exp_t q[$];
  int   asserts = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   n_done  = 0;
  bit   m_busy  = 0;
  int   m_ptr   = 0;
  int   cur_dly = 0;
  int   acc_cnt [N];   // acceptances seen by the monitor
  int   acc_seen[N];   // acceptances consumed by the driver
  int   next_dly = 5;
  bit   refill = 0, rand_mode = 0, junk = 0;

  initial forever @(posedge clk) cyc++;

  task automatic check(string nm, logic [CW-1:0] act, logic [CW-1:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] code_of(logic [DW-1:0] d);
    return {d[63:0] ^ 64'hA5A5_5A5A_C3C3_3C3C, d};
  endfunction

  // ---------------- monitor / reference model ----------------
  logic [N-1:0] exp_rr;
  int           w, j;
  exp_t         e;

  initial begin
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_busy = 0;
        m_ptr  = 0;
        continue;
      end
      check("busy", busy, m_busy);
      if (m_busy) begin
        check("enc_clrn", enc_clrn, cyc != q[0].g + 1);
        check("enc_en", enc_en, cyc == q[0].g + 2);
        check("grant_id", grant_id, q[0].id);
      end else begin
        check("enc_clrn_idle", enc_clrn, 1'b1);
        check("enc_en_idle", enc_en, 1'b0);
      end
      // Round-robin: search upward from the pointer for a valid requester.
      exp_rr = '0;
      w      = -1;
      if (!m_busy && enc_ready) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
        if (w >= 0) exp_rr = N'(1) << w;
      end
      check("req_ready", req_ready, exp_rr);
      if (m_busy) begin
        check("rsp_valid", rsp_valid, (cyc >= q[0].t) ? N'(1) << q[0].id : N'(0));
        if (cyc >= q[0].t) begin
          check("rsp_data", rsp_data, q[0].code);
          check("rsp_err", rsp_err, q[0].err);
          if (rsp_ready[q[0].id]) begin
            m_ptr  = (q[0].id + 1) % N;
            m_busy = 0;
            n_done++;
            void'(q.pop_front());
          end
        end
      end else begin
        check("rsp_valid_idle", rsp_valid, '0);
      end
      if (w >= 0) begin
        e.id   = w;
        e.g    = cyc;
        e.err  = (next_dly > TO);
        e.code = e.err ? '0 : code_of(req_data[w*DW +: DW]);
        e.t    = cyc + 3 + (e.err ? TO : next_dly);
        cur_dly = next_dly;
        q.push_back(e);
        m_busy = 1;
        acc_cnt[w]++;
      end
    end
  end

  // ---------------- engine model ----------------
  int          eng_cnt = 0;
  logic [DW-1:0] eng_data;
  initial forever begin
    @(posedge clk); #1;
    enc_valid = 1'b0;
    if (rst) eng_cnt = 0;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        enc_valid = 1'b1;
        enc_code  = code_of(eng_data);
      end
    end else if (enc_en) begin
      eng_data = enc_data;
      eng_cnt  = (cur_dly > TO) ? 0 : cur_dly;
    end else if (junk && $urandom_range(0, 3) == 0) begin
      // Stray valid while the controller is not waiting; must be ignored.
      enc_valid = 1'b1;
      enc_code  = {13{$urandom}};
    end
  end

  // ---------------- driver ----------------
  task automatic new_data(int i);
    logic [351:0] tmp;
    for (int k = 0; k < 11; k++) tmp[k*32 +: 32] = $urandom;
    req_data[i*DW +: DW] = tmp[DW-1:0];
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc_cnt[i] != acc_seen[i]) begin
        acc_seen[i] = acc_cnt[i];
        req_valid[i] = refill;
        if (refill) new_data(i);
      end
      if (rand_mode && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        new_data(i);
      end
    end
    if (rand_mode) begin
      rsp_ready = N'($urandom);
      enc_ready = ($urandom_range(0, 4) != 0);
      next_dly  = $urandom_range(1, 20);
    end
  endtask

  task automatic wait_done(int target, int budget);
    int n = 0;
    while (n_done < target && n < budget) begin step(); n++; end
    check("wait_done_budget", n_done, target);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((req_valid != '0 || m_busy) && n < budget) begin step(); n++; end
    check("drain_budget", {req_valid, m_busy}, '0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) acc_seen[i] = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_clrn", enc_clrn, 1'b1);
    check("rst_en", enc_en, 1'b0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_grant_id", grant_id, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_enc_data", enc_data, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request, bytes 0x01..0x2A, engine answers 5 cycles after start.
    for (int k = 0; k < 42; k++) req_data[(41-k)*8 +: 8] = 8'(k + 1);
    req_valid = 2'b01; rsp_ready = 2'b11; next_dly = 5;
    wait_done(n_done + 1, 100);
    drain(50);

    // Contention: both requesters valid continuously.
    new_data(0); new_data(1);
    refill = 1; req_valid = 2'b11; next_dly = 3;
    wait_done(n_done + 4, 200);
    refill = 0;
    drain(100);

    // Timeout: engine never answers.
    new_data(0); req_valid = 2'b01; next_dly = NEVER;
    wait_done(n_done + 1, 1200);
    // Valid lands on the last WAIT cycle.
    new_data(0); req_valid = 2'b01; next_dly = TO;
    wait_done(n_done + 1, 1200);

    // Response backpressure while a second request arrives.
    rsp_ready = 2'b00; new_data(0); req_valid = 2'b01; next_dly = 4;
    n = 0;
    while (rsp_valid == '0 && n < 50) begin step(); n++; end
    check("bp_rsp_seen", rsp_valid, 2'b01);
    new_data(1); req_valid[1] = 1'b1;
    repeat (10) step();
    rsp_ready = 2'b11;
    drain(100);

    // Randomized traffic, backpressure, engine stalls and stray valids.
    rand_mode = 1; junk = 1;
    repeat (600) step();
    rand_mode = 0; junk = 0; rsp_ready = 2'b11; enc_ready = 1'b1; next_dly = 3;
    drain(300);

    // Reset in WAIT: pointer is 1 before, requester 1 is in flight.
    new_data(0); req_valid = 2'b01; next_dly = 3;
    drain(50);
    new_data(1); req_valid = 2'b10; next_dly = NEVER;
    n = 0;
    while (!m_busy && n < 20) begin step(); n++; end
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("rst_wait_busy", busy, 1'b0);
    check("rst_wait_clrn", enc_clrn, 1'b1);
    check("rst_wait_en", enc_en, 1'b0);
    check("rst_wait_rsp_valid", rsp_valid, '0);
    check("rst_wait_grant_id", grant_id, '0);
    req_valid = '0;
    for (int i = 0; i < N; i++) acc_seen[i] = acc_cnt[i];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    new_data(0); new_data(1); req_valid = 2'b11; next_dly = 2;
    step();
    check("after_rst_first_owner", grant_id, '0);
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
